vending_ctrl_param: RTL and testbench

//  Parametrised vending-machine controller: N coin channels with configurable values,

---
 rtl/vending_pkg.sv | 13 +
 rtl/vending_ctrl_param.sv | 121 ++++++++++++
 tb/tb_vending_ctrl_param.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the parametrised vending controller.
// Credit is counted in units of UNIT_BANI.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int UNIT_BANI = 50;

endpackage

// File: rtl/vending_ctrl_param.sv
// Vending-machine controller: credits one-hot coin pulses, vends at PRICE,
// and pays any remaining credit back one unit per change handshake.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int                      N_COIN    = 2,
  parameter int                      VAL_W     = 4,
  parameter logic [N_COIN*VAL_W-1:0] COIN_VALS = {4'd2, 4'd1},
  parameter int                      PRICE     = 5,
  parameter int                      CREDIT_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_COIN-1:0]   coin,
  input  logic                cancel,
  output logic                vend,
  output logic                chg_valid,
  input  logic                chg_ready,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  function automatic int maxCoin();
    int m;
    m = 0;
    for (int i = 0; i < N_COIN; i++) begin
      if (int'(COIN_VALS[i*VAL_W +: VAL_W]) > m) m = int'(COIN_VALS[i*VAL_W +: VAL_W]);
    end
    return m;
  endfunction

  localparam int                  MAX_COIN = maxCoin();
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);

  // Credit can never exceed PRICE-1 plus the largest coin, so no overflow path exists.
  generate
    if (PRICE < 1 || (PRICE - 1 + MAX_COIN) >= (2 ** CREDIT_W)) begin : g_bad_params
      $error("vending_ctrl_param: PRICE must be >= 1 and PRICE-1+max coin must fit in CREDIT_W");
    end
  endgenerate

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_reject;

  state_t              w_next_state;
  logic [CREDIT_W-1:0] w_next_credit;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_remain;
  logic                w_legal;
  logic                w_any;
  logic                w_reject;

  always_comb begin
    w_coin_val = '0;
    for (int i = 0; i < N_COIN; i++) begin
      if (coin[i]) w_coin_val = CREDIT_W'(COIN_VALS[i*VAL_W +: VAL_W]);
    end
  end

  assign w_legal  = $onehot(coin);
  assign w_any    = |coin;
  assign w_sum    = r_credit + w_coin_val;
  assign w_remain = r_credit - PRICE_C;

  always_comb begin
    w_next_state  = r_state;
    w_next_credit = r_credit;
    w_reject      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cancel) begin
          w_reject = w_any;
          if (r_credit != '0) w_next_state = CHANGE;
        end else if (w_legal) begin
          w_next_credit = w_sum;
          if (w_sum >= PRICE_C) w_next_state = VEND;
        end else begin
          w_reject = w_any;
        end
      end
      VEND: begin
        w_reject      = w_any;
        w_next_credit = w_remain;
        w_next_state  = (w_remain != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_reject = w_any;
        if (chg_ready) begin
          w_next_credit = r_credit - CREDIT_W'(1);
          if (r_credit == CREDIT_W'(1)) w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state  = IDLE;
        w_next_credit = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_credit      <= w_next_credit;
      r_coin_reject <= w_reject;
    end
  end

  assign vend        = (r_state == VEND);
  assign chg_valid   = (r_state == CHANGE);
  assign busy        = (r_state == VEND) || (r_state == CHANGE);
  assign coin_reject = r_coin_reject;
  assign credit      = r_credit;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Self-checking bench: a behavioural model queues the expected outputs of every
// driven cycle and a monitor compares them one cycle later; a second instance covers PRICE=3.
module tb_vending_ctrl_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] coin;
  logic       cancel;
  logic       chg_ready;
  logic       vend, chg_valid, coin_reject, busy;
  logic [3:0] credit;

  logic [1:0] coin2;
  logic       cancel2;
  logic       rdy2;
  logic       vend2, chgValid2, reject2, busy2;
  logic [3:0] credit2;

  typedef struct packed {
    logic       vend;
    logic       chgValid;
    logic       reject;
    logic [3:0] credit;
    logic       busy;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  int checks    = 0;
  int errors    = 0;
  int mState    = 0;
  int mCredit   = 0;
  int hsCount   = 0;
  int vendCount = 0;
  int chgSeen   = 0;
  int rejCount  = 0;
  int v0, h0, c0, r0;

  vending_ctrl_param dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin       (coin),
    .cancel     (cancel),
    .vend       (vend),
    .chg_valid  (chg_valid),
    .chg_ready  (chg_ready),
    .coin_reject(coin_reject),
    .credit     (credit),
    .busy       (busy)
  );

  vending_ctrl_param #(
    .PRICE    (3),
    .COIN_VALS({4'd5, 4'd1})
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin       (coin2),
    .cancel     (cancel2),
    .vend       (vend2),
    .chg_valid  (chgValid2),
    .chg_ready  (rdy2),
    .coin_reject(reject2),
    .credit     (credit2),
    .busy       (busy2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must look like after the next edge.
  task automatic applyStimulus(input logic [1:0] c, input logic can, input logic rdy);
    int   nState, nCredit;
    logic nRej;
    exp_t x;
    @(negedge clk);
    coin      = c;
    cancel    = can;
    chg_ready = rdy;
    nState  = mState;
    nCredit = mCredit;
    nRej    = 1'b0;
    case (mState)
      0: begin
        if (can) begin
          nRej = (c != 2'b00);
          if (mCredit > 0) nState = 2;
        end else if (c == 2'b01 || c == 2'b10) begin
          nCredit = mCredit + ((c == 2'b10) ? 2 : 1);
          if (nCredit >= 5) nState = 1;
        end else begin
          nRej = (c != 2'b00);
        end
      end
      1: begin
        nRej    = (c != 2'b00);
        nCredit = mCredit - 5;
        nState  = (nCredit > 0) ? 2 : 0;
      end
      default: begin
        nRej = (c != 2'b00);
        if (rdy) begin
          nCredit = mCredit - 1;
          if (nCredit == 0) nState = 0;
        end
      end
    endcase
    x.vend     = (nState == 1);
    x.chgValid = (nState == 2);
    x.reject   = nRej;
    x.credit   = 4'(nCredit);
    x.busy     = (nState != 0);
    expQ.push_back(x);
    mState  = nState;
    mCredit = nCredit;
  endtask

  always @(posedge clk) begin
    if (chg_valid && chg_ready) hsCount++;
    #1;
    if (vend) vendCount++;
    if (chg_valid) chgSeen++;
    if (coin_reject) rejCount++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("sb_vend", int'(vend), int'(e.vend));
      checkOutput("sb_chg_valid", int'(chg_valid), int'(e.chgValid));
      checkOutput("sb_reject", int'(coin_reject), int'(e.reject));
      checkOutput("sb_credit", int'(credit), int'(e.credit));
      checkOutput("sb_busy", int'(busy), int'(e.busy));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; coin = 2'b00; cancel = 1'b0; chg_ready = 1'b0;
    coin2 = 2'b00; cancel2 = 1'b0; rdy2 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_credit", int'(credit), 0);
    checkOutput("rst_vend", int'(vend), 0);
    checkOutput("rst_chg_valid", int'(chg_valid), 0);
    checkOutput("rst_reject", int'(coin_reject), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // five 1-unit coins reach the price exactly
    v0 = vendCount; c0 = chgSeen;
    repeat (5) applyStimulus(2'b01, 1'b0, 1'b0);
    repeat (3) applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t1_vends", vendCount - v0, 1);
    checkOutput("t1_no_change", chgSeen - c0, 0);

    // three 2-unit coins overpay by one unit
    v0 = vendCount; h0 = hsCount;
    repeat (3) applyStimulus(2'b10, 1'b0, 1'b1);
    repeat (3) applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t2_vends", vendCount - v0, 1);
    checkOutput("t2_handshakes", hsCount - h0, 1);

    // cancel with credit 3, change actuator stalls twice
    h0 = hsCount; v0 = vendCount;
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b1);
    repeat (2) applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t3_handshakes", hsCount - h0, 3);
    checkOutput("t3_no_vend", vendCount - v0, 0);

    // illegal coin in IDLE, coin during VEND and during CHANGE
    r0 = rejCount;
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    repeat (3) applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    repeat (2) applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t4_rejects", rejCount - r0, 3);

    // cancel together with a coin at credit 2
    r0 = rejCount; h0 = hsCount;
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b1);
    repeat (2) applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t5_rejects", rejCount - r0, 1);
    checkOutput("t5_handshakes", hsCount - h0, 2);

    // asynchronous reset in the middle of a refund
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    checkOutput("t6_pre_credit", int'(credit), 3);
    checkOutput("t6_pre_chg_valid", int'(chg_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_credit", int'(credit), 0);
    checkOutput("t6_rst_chg_valid", int'(chg_valid), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    mState = 0; mCredit = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("queue_drained", expQ.size(), 0);

    // PRICE=3 with a 5-unit coin: vend then refund 2
    @(negedge clk);
    coin2 = 2'b10;
    @(negedge clk);
    coin2 = 2'b00;
    checkOutput("p3_credit_5", int'(credit2), 5);
    checkOutput("p3_vend", int'(vend2), 1);
    checkOutput("p3_busy_vend", int'(busy2), 1);
    @(negedge clk);
    checkOutput("p3_credit_2", int'(credit2), 2);
    checkOutput("p3_vend_gone", int'(vend2), 0);
    checkOutput("p3_chg_valid", int'(chgValid2), 1);
    rdy2 = 1'b1;
    @(negedge clk);
    checkOutput("p3_credit_1", int'(credit2), 1);
    checkOutput("p3_chg_held", int'(chgValid2), 1);
    @(negedge clk);
    rdy2 = 1'b0;
    checkOutput("p3_credit_0", int'(credit2), 0);
    checkOutput("p3_chg_done", int'(chgValid2), 0);
    checkOutput("p3_idle", int'(busy2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
